// File: rtl/wbc_rst_seq_pkg.sv
// Shared types and constants for the board reset/timebase sequencer.
package wbc_rst_seq_pkg;

    // Sequencer states, fixed encoding so the state is stable across tools.
    typedef enum logic [1:0] {
        ST_PWR = 2'd0,
        ST_SYS = 2'd1,
        ST_RUN = 2'd2,
        ST_BTN = 2'd3
    } seq_state_t;

    localparam int US_PER_MS  = 1000;
    localparam int HZ_PER_MHZ = 1000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wbc_tick.sv
// Free-running microsecond / millisecond strobe generator.
// ena_ms is issued together with the ena_us that wraps the ms counter.
module wbc_tick
    import wbc_rst_seq_pkg::*;
#(
    parameter int US_DIV = 50
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_ena_us,
    output logic o_ena_ms
);

    localparam int US_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int MS_W = $clog2(US_PER_MS);
    localparam logic [US_W-1:0] US_LAST = US_W'(US_DIV - 1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(US_PER_MS - 1);

    logic [US_W-1:0] r_us_cnt;
    logic [MS_W-1:0] r_ms_cnt;
    logic            r_ena_us;
    logic            r_ena_ms;
    logic            w_us_wrap;
    logic            w_ms_wrap;

    assign w_us_wrap = (r_us_cnt == US_LAST);
    assign w_ms_wrap = (r_ms_cnt == MS_LAST);

    // Prescaler counters and registered strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_us_cnt <= '0;
            r_ms_cnt <= '0;
            r_ena_us <= 1'b0;
            r_ena_ms <= 1'b0;
        end else begin
            r_ena_us <= w_us_wrap;
            r_ena_ms <= w_us_wrap && w_ms_wrap;
            if (w_us_wrap) begin
                r_us_cnt <= '0;
                if (w_ms_wrap) r_ms_cnt <= '0;
                else           r_ms_cnt <= r_ms_cnt + 1'b1;
            end else begin
                r_us_cnt <= r_us_cnt + 1'b1;
            end
        end
    end

    assign o_ena_us = r_ena_us;
    assign o_ena_ms = r_ena_ms;

endmodule

// File: rtl/wbc_rst_seq.sv
// Reset and timebase sequencer between the PLL and the CPU wrapper.
// PLL lock is the async reset; the button is synchronised and debounced.
//
//  state | meaning
//  PWR   | pwr_rst and sys_rst held, waiting PWR_MS after lock
//  SYS   | sys_rst held, waiting SYS_US; a pressed button diverts to BTN
//  RUN   | core running, both resets released
//  BTN   | sys_rst held while the debounced button is pressed
module wbc_rst_seq
    import wbc_rst_seq_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int PWR_MS = 10,
    parameter int SYS_US = 100,
    parameter int DEB_MS = 5
) (
    input  logic sys_clk_p,
    input  logic sys_plock,
    input  logic ext_reset,
    output logic pwr_rst,
    output logic sys_rst,
    output logic ena_us,
    output logic ena_ms,
    output logic btn_db
);

    localparam int US_DIV = CLK_HZ / HZ_PER_MHZ;
    localparam int SEQ_W  = $clog2(max_int(PWR_MS, SYS_US) + 1);
    localparam int DEB_W  = $clog2(DEB_MS + 1);
    localparam logic [SEQ_W-1:0] PWR_LAST = SEQ_W'(PWR_MS - 1);
    localparam logic [SEQ_W-1:0] SYS_LAST = SEQ_W'(SYS_US - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_MS);

    logic             w_ena_us;
    logic             w_ena_ms;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_btn_db;
    seq_state_t       r_state;
    logic [SEQ_W-1:0] r_seq_cnt;
    logic             r_pwr_rst;
    logic             r_sys_rst;

    wbc_tick #(
        .US_DIV (US_DIV)
    ) u_tick (
        .i_clk    (sys_clk_p),
        .i_rst_n  (sys_plock),
        .o_ena_us (w_ena_us),
        .o_ena_ms (w_ena_ms)
    );

    // Button synchroniser and debounce; the level is only taken over once it
    // has been stable for DEB_MS strobes, so a fresh edge never slips through.
    always_ff @(posedge sys_clk_p or negedge sys_plock) begin
        if (!sys_plock) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_prev    <= 1'b0;
            r_deb_cnt <= '0;
            r_btn_db  <= 1'b0;
        end else begin
            r_sync1 <= ext_reset;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_sync2 != r_prev) begin
                r_deb_cnt <= '0;
            end else begin
                if (w_ena_ms && (r_deb_cnt != DEB_MAX)) r_deb_cnt <= r_deb_cnt + 1'b1;
                if (r_deb_cnt == DEB_MAX)               r_btn_db  <= r_sync2;
            end
        end
    end

    // Reset sequencing FSM; seq_cnt restarts on every state entry.
    always_ff @(posedge sys_clk_p or negedge sys_plock) begin
        if (!sys_plock) begin
            r_state   <= ST_PWR;
            r_seq_cnt <= '0;
            r_pwr_rst <= 1'b1;
            r_sys_rst <= 1'b1;
        end else begin
            case (r_state)
                ST_PWR: begin
                    if (w_ena_ms) begin
                        if (r_seq_cnt == PWR_LAST) begin
                            r_state   <= ST_SYS;
                            r_seq_cnt <= '0;
                            r_pwr_rst <= 1'b0;
                        end else begin
                            r_seq_cnt <= r_seq_cnt + 1'b1;
                        end
                    end
                end
                ST_SYS: begin
                    if (r_btn_db) begin
                        r_state   <= ST_BTN;
                        r_seq_cnt <= '0;
                        r_sys_rst <= 1'b1;
                    end else if (w_ena_us) begin
                        if (r_seq_cnt == SYS_LAST) begin
                            r_state   <= ST_RUN;
                            r_seq_cnt <= '0;
                            r_sys_rst <= 1'b0;
                        end else begin
                            r_seq_cnt <= r_seq_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_btn_db) begin
                        r_state   <= ST_BTN;
                        r_seq_cnt <= '0;
                        r_sys_rst <= 1'b1;
                    end
                end
                ST_BTN: begin
                    r_sys_rst <= 1'b1;
                    if (!r_btn_db) begin
                        r_state   <= ST_SYS;
                        r_seq_cnt <= '0;
                    end
                end
                default: begin
                    // Recover through a full SYS hold without touching pwr_rst.
                    r_state   <= ST_SYS;
                    r_seq_cnt <= '0;
                    r_sys_rst <= 1'b1;
                end
            endcase
        end
    end

    assign pwr_rst = r_pwr_rst;
    assign sys_rst = r_sys_rst;
    assign ena_us  = w_ena_us;
    assign ena_ms  = w_ena_ms;
    assign btn_db  = r_btn_db;

endmodule

// File: tb/tb_wbc_rst_seq.sv
// Bench for wbc_rst_seq at CLK_HZ=4 MHz (US_DIV=4), PWR_MS=2, SYS_US=10, DEB_MS=3.
module tb_wbc_rst_seq;

    localparam int CLK_HZ = 4000000;
    localparam int PWR_MS = 2;
    localparam int SYS_US = 10;
    localparam int DEB_MS = 3;
    localparam int NV     = 13;

    logic sys_clk_p = 1'b0;
    logic sys_plock = 1'b0;
    logic ext_reset = 1'b0;
    logic pwr_rst, sys_rst, ena_us, ena_ms, btn_db;

    wbc_rst_seq #(
        .CLK_HZ (CLK_HZ),
        .PWR_MS (PWR_MS),
        .SYS_US (SYS_US),
        .DEB_MS (DEB_MS)
    ) dut (
        .sys_clk_p (sys_clk_p),
        .sys_plock (sys_plock),
        .ext_reset (ext_reset),
        .pwr_rst   (pwr_rst),
        .sys_rst   (sys_rst),
        .ena_us    (ena_us),
        .ena_ms    (ena_ms),
        .btn_db    (btn_db)
    );

    always #5 sys_clk_p = ~sys_clk_p;

    // Output vector order: {pwr_rst, sys_rst, ena_us, ena_ms, btn_db}
    typedef struct {
        string      name;
        int         cyc;
        logic       pl;
        logic       btn;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] exp;
    } sb_t;

    vec_t vecs [NV];
    sb_t  sb_q [$];

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   inv_viol  = 0;
    int   db_edges  = 0;
    int   sys_edges = 0;
    logic prev_pwr  = 1'b1;
    logic prev_db   = 1'b0;
    logic prev_sys  = 1'b1;
    int   p_cyc, b_up, s_up, b_dn, s_dn, pf;

    function automatic logic [4:0] outs();
        return {pwr_rst, sys_rst, ena_us, ena_ms, btn_db};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pwr_rst;
            1:       return sys_rst;
            default: return btn_db;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s got=%0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock; cyc counts edges since lock. Invariants watched every cycle.
    task automatic tick();
        @(posedge sys_clk_p);
        if (sys_plock) cyc++;
        @(negedge sys_clk_p);
        if (pwr_rst && !sys_rst)               inv_viol++;
        if (ena_ms && !ena_us)                 inv_viol++;
        if (sys_plock && pwr_rst && !prev_pwr) inv_viol++;
        if (btn_db != prev_db)                 db_edges++;
        if (sys_rst != prev_sys)               sys_edges++;
        prev_pwr = pwr_rst;
        prev_db  = btn_db;
        prev_sys = sys_rst;
    endtask

    task automatic wait_for(input int sel, input logic val, input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (sig(sel) === val) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic lock_cycle();
        sys_plock = 1'b0;
        repeat (3) tick();
        sys_plock = 1'b1;
        cyc = 0;
    endtask

    // Power-up sequence from lock release, driven and checked from the table.
    task automatic run_table(input string tag);
        sb_t e;
        sys_plock = 1'b1;
        cyc = 0;
        for (int i = 0; i < NV; i++) begin
            sys_plock = vecs[i].pl;
            ext_reset = vecs[i].btn;
            sb_q.push_back('{name: vecs[i].name, exp: vecs[i].exp});
            while (cyc < vecs[i].cyc) tick();
            e = sb_q.pop_front();
            check({tag, e.name}, 32'(outs()), 32'(e.exp));
        end
    endtask

    initial begin
        vecs[0]  = '{"c1",    1,    1'b1, 1'b0, 5'b11000};
        vecs[1]  = '{"c3",    3,    1'b1, 1'b0, 5'b11000};
        vecs[2]  = '{"c4_us", 4,    1'b1, 1'b0, 5'b11100};
        vecs[3]  = '{"c5",    5,    1'b1, 1'b0, 5'b11000};
        vecs[4]  = '{"c8_us", 8,    1'b1, 1'b0, 5'b11100};
        vecs[5]  = '{"c3996", 3996, 1'b1, 1'b0, 5'b11100};
        vecs[6]  = '{"c4000_ms", 4000, 1'b1, 1'b0, 5'b11110};
        vecs[7]  = '{"c4001", 4001, 1'b1, 1'b0, 5'b11000};
        vecs[8]  = '{"c8000_ms", 8000, 1'b1, 1'b0, 5'b11110};
        vecs[9]  = '{"c8001_pwr_off", 8001, 1'b1, 1'b0, 5'b01000};
        vecs[10] = '{"c8040", 8040, 1'b1, 1'b0, 5'b01100};
        vecs[11] = '{"c8041_sys_off", 8041, 1'b1, 1'b0, 5'b00000};
        vecs[12] = '{"c8044", 8044, 1'b1, 1'b0, 5'b00100};

        sys_plock = 1'b0;
        ext_reset = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'(outs()), 32'(5'b11000));

        run_table("boot0_");

        // Button press while running.
        ext_reset = 1'b1;
        p_cyc = cyc;
        wait_for(2, 1'b1, 17000, b_up);
        check_range("run_btn_rise_latency", b_up - p_cyc, 8000, 16002);
        wait_for(1, 1'b1, 4, s_up);
        check("run_sys_after_btn", 32'(s_up - b_up), 32'd1);
        while (cyc < p_cyc + 13000) tick();
        check("run_hold_sys", 32'(sys_rst), 32'd1);
        check("run_hold_pwr", 32'(pwr_rst), 32'd0);
        ext_reset = 1'b0;
        wait_for(2, 1'b0, 17000, b_dn);
        check("run_sys_at_btn_fall", 32'(sys_rst), 32'd1);
        wait_for(1, 1'b0, 100, s_dn);
        check_range("run_sys_hold_after_release", s_dn - b_dn, 36, 44);
        check("run_pwr_after_release", 32'(pwr_rst), 32'd0);

        // 1 kHz bounce must never reach btn_db or the FSM.
        db_edges  = 0;
        sys_edges = 0;
        for (int k = 0; k < 6; k++) begin
            ext_reset = (k % 2 == 0);
            repeat (2000) tick();
        end
        ext_reset = 1'b0;
        repeat (100) tick();
        check("bounce_btn_edges", 32'(db_edges), 32'd0);
        check("bounce_sys_edges", 32'(sys_edges), 32'd0);
        check("bounce_btn_level", 32'(btn_db), 32'd0);

        // Button pressed during the power-on hold.
        lock_cycle();
        while (cyc < 1000) tick();
        ext_reset = 1'b1;
        wait_for(0, 1'b0, 8100, pf);
        check_range("pwrpress_pwr_fall", pf, 7998, 8002);
        wait_for(2, 1'b1, 16000, b_up);
        check_range("pwrpress_btn_rise", b_up, 11998, 12006);
        tick();
        check("pwrpress_sys_in_btn", 32'(sys_rst), 32'd1);
        while (cyc < 14000) tick();
        ext_reset = 1'b0;
        wait_for(2, 1'b0, 17000, b_dn);
        check("pwrpress_sys_at_btn_fall", 32'(sys_rst), 32'd1);
        wait_for(1, 1'b0, 100, s_dn);
        check_range("pwrpress_sys_hold", s_dn - b_dn, 36, 44);
        check("pwrpress_pwr_stays_low", 32'(pwr_rst), 32'd0);

        // Lock lost in the middle of SYS: outputs reset without a clock edge.
        lock_cycle();
        while (cyc < 8020) tick();
        check("pre_drop_in_sys", 32'(outs()), 32'(5'b01100));
        #2;
        sys_plock = 1'b0;
        #1;
        check("async_drop_outputs", 32'(outs()), 32'(5'b11000));
        @(negedge sys_clk_p);
        prev_pwr = pwr_rst;
        prev_sys = sys_rst;
        prev_db  = btn_db;
        run_table("reboot_");

        check("invariants", 32'(inv_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
